// File: rtl/fmul_rr_scheduler.sv
// Round-robin scheduler sharing one floating-point multiplier among NUM_REQ requesters.
// Define FMUL_RR_SCHEDULER_STATS_EN to add saturating grant and response-stall counters.
module fmul_rr_scheduler #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REQ    = 4,
  parameter int ID_WIDTH   = $clog2(NUM_REQ),
  parameter int MUL_LAT    = 0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_a,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_b,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [DATA_WIDTH-1:0]         rsp_data,
  output logic [ID_WIDTH-1:0]           rsp_id,
  output logic [DATA_WIDTH-1:0]         fmul_a,
  output logic [DATA_WIDTH-1:0]         fmul_b,
  input  logic [DATA_WIDTH-1:0]         fmul_c,
  output logic                          busy
`ifdef FMUL_RR_SCHEDULER_STATS_EN
  ,
  output logic [NUM_REQ*16-1:0]         stat_grants,
  output logic [15:0]                   stat_stall
`endif
);

  localparam int LAT_W = (MUL_LAT > 0) ? $clog2(MUL_LAT + 1) : 1;
  localparam int CW    = ID_WIDTH + 1;

  typedef enum logic [1:0] {IDLE, CALC, RESP} state_e;

  state_e                state_q, state_d;
  logic [ID_WIDTH-1:0]   rr_ptr_q, rr_ptr_d;
  logic [LAT_W-1:0]      lat_cnt_q, lat_cnt_d;
  logic [DATA_WIDTH-1:0] fmul_a_q, fmul_a_d;
  logic [DATA_WIDTH-1:0] fmul_b_q, fmul_b_d;
  logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic [ID_WIDTH-1:0]   rsp_id_q, rsp_id_d;

  logic                  grant_found;
  logic [ID_WIDTH-1:0]   grant_idx;
  logic [CW-1:0]         cand;

  // Search upward from rr_ptr with wrap; the extra bit keeps rr_ptr+i from overflowing.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      cand = {1'b0, rr_ptr_q} + CW'(i);
      if (cand >= CW'(NUM_REQ)) cand = cand - CW'(NUM_REQ);
      if (!grant_found && req_valid[cand[ID_WIDTH-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = cand[ID_WIDTH-1:0];
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    lat_cnt_d  = lat_cnt_q;
    fmul_a_d   = fmul_a_q;
    fmul_b_d   = fmul_b_q;
    rsp_data_d = rsp_data_q;
    rsp_id_d   = rsp_id_q;
    req_ready  = '0;
    case (state_q)
      IDLE: begin
        if (grant_found && !rst) begin
          req_ready[grant_idx] = 1'b1;
          fmul_a_d  = req_a[int'(grant_idx)*DATA_WIDTH +: DATA_WIDTH];
          fmul_b_d  = req_b[int'(grant_idx)*DATA_WIDTH +: DATA_WIDTH];
          rsp_id_d  = grant_idx;
          rr_ptr_d  = (grant_idx == ID_WIDTH'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
          lat_cnt_d = '0;
          state_d   = CALC;
        end
      end
      CALC: begin
        lat_cnt_d = lat_cnt_q + 1'b1;
        if (lat_cnt_q == LAT_W'(MUL_LAT)) begin
          rsp_data_d = fmul_c;
          state_d    = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      lat_cnt_q  <= '0;
      fmul_a_q   <= '0;
      fmul_b_q   <= '0;
      rsp_data_q <= '0;
      rsp_id_q   <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      lat_cnt_q  <= lat_cnt_d;
      fmul_a_q   <= fmul_a_d;
      fmul_b_q   <= fmul_b_d;
      rsp_data_q <= rsp_data_d;
      rsp_id_q   <= rsp_id_d;
    end
  end

  assign rsp_valid = (state_q == RESP);
  assign busy      = (state_q != IDLE);
  assign rsp_data  = rsp_data_q;
  assign rsp_id    = rsp_id_q;
  assign fmul_a    = fmul_a_q;
  assign fmul_b    = fmul_b_q;

`ifdef FMUL_RR_SCHEDULER_STATS_EN
  logic [15:0] grants_q [NUM_REQ];
  logic [15:0] grants_d [NUM_REQ];
  logic [15:0] stall_q, stall_d;

  always_comb begin
    stall_d     = stall_q;
    stat_grants = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      grants_d[i] = grants_q[i];
      if (state_q == IDLE && grant_found && grant_idx == ID_WIDTH'(i) && grants_q[i] != '1)
        grants_d[i] = grants_q[i] + 16'd1;
      stat_grants[i*16 +: 16] = grants_q[i];
    end
    if (state_q == RESP && !rsp_ready && stall_q != '1) stall_d = stall_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_REQ; i++) grants_q[i] <= '0;
      stall_q <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_REQ; i++) grants_q[i] <= grants_d[i];
      stall_q <= stall_d;
    end
  end

  assign stat_stall = stall_q;
`endif

endmodule

// File: tb/tb_fmul_rr_scheduler.sv
// Scoreboard bench for fmul_rr_scheduler: a combinational (MUL_LAT=0) and a 3-stage (MUL_LAT=3) instance.
module tb_fmul_rr_scheduler;
  localparam int DW = 32;
  localparam int NR = 4;
  localparam int IW = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [NR-1:0]    rv0, rr0, rv3, rr3;
  logic [NR*DW-1:0] a0, b0, a3, b3;
  logic             rspv0, rspr0, busy0, rspv3, rspr3, busy3;
  logic [DW-1:0]    rspd0, fa0, fb0, fc0, rspd3, fa3, fb3, fc3;
  logic [IW-1:0]    rspid0, rspid3;
`ifdef FMUL_RR_SCHEDULER_STATS_EN
  logic [NR*16-1:0] sg0, sg3;
  logic [15:0]      ss0, ss3;
`endif

  fmul_rr_scheduler #(.DATA_WIDTH(DW), .NUM_REQ(NR), .ID_WIDTH(IW), .MUL_LAT(0)) dut0 (
    .clk(clk), .rst(rst), .req_valid(rv0), .req_ready(rr0), .req_a(a0), .req_b(b0),
    .rsp_valid(rspv0), .rsp_ready(rspr0), .rsp_data(rspd0), .rsp_id(rspid0),
    .fmul_a(fa0), .fmul_b(fb0), .fmul_c(fc0), .busy(busy0)
`ifdef FMUL_RR_SCHEDULER_STATS_EN
    , .stat_grants(sg0), .stat_stall(ss0)
`endif
  );

  fmul_rr_scheduler #(.DATA_WIDTH(DW), .NUM_REQ(NR), .ID_WIDTH(IW), .MUL_LAT(3)) dut3 (
    .clk(clk), .rst(rst), .req_valid(rv3), .req_ready(rr3), .req_a(a3), .req_b(b3),
    .rsp_valid(rspv3), .rsp_ready(rspr3), .rsp_data(rspd3), .rsp_id(rspid3),
    .fmul_a(fa3), .fmul_b(fb3), .fmul_c(fc3), .busy(busy3)
`ifdef FMUL_RR_SCHEDULER_STATS_EN
    , .stat_grants(sg3), .stat_stall(ss3)
`endif
  );

  // IEEE single multiply via double precision (normal numbers; test products are exact).
  function automatic real sp2real(input logic [31:0] x);
    logic [10:0] e;
    logic [63:0] d;
    if (x[30:23] == 8'd0) return 0.0;
    e = 11'(x[30:23]) + 11'd896;
    d = {x[31], e, x[22:0], 29'd0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] real2sp(input real r);
    logic [63:0] d;
    logic [10:0] e;
    d = $realtobits(r);
    if (d[62:0] == 63'd0) return {d[63], 31'd0};
    e = d[62:52] - 11'd896;
    return {d[63], e[7:0], d[51:29]};
  endfunction

  function automatic logic [31:0] fmul_model(input logic [31:0] x, input logic [31:0] y);
    return real2sp(sp2real(x) * sp2real(y));
  endfunction

  assign fc0 = fmul_model(fa0, fb0);

  logic [DW-1:0] p1, p2, p3;
  always @(posedge clk) begin
    p1 <= fmul_model(fa3, fb3);
    p2 <= p1;
    p3 <= p2;
  end
  assign fc3 = p3;

  typedef struct packed {
    logic [IW-1:0] id;
    logic [DW-1:0] data;
  } exp_t;

  exp_t q0[$];
  exp_t q3[$];
  exp_t e0, e3;
  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && rspv0 && rspr0) begin
      if (q0.size() == 0) begin
        total++;
        bad++;
        $display("FAIL rsp0_unexpected: got id=%0d data=%0h expected none", rspid0, rspd0);
      end else begin
        e0 = q0.pop_front();
        chk("rsp0_id", 64'(rspid0), 64'(e0.id));
        chk("rsp0_data", 64'(rspd0), 64'(e0.data));
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && rspv3 && rspr3) begin
      if (q3.size() == 0) begin
        total++;
        bad++;
        $display("FAIL rsp3_unexpected: got id=%0d data=%0h expected none", rspid3, rspd3);
      end else begin
        e3 = q3.pop_front();
        chk("rsp3_id", 64'(rspid3), 64'(e3.id));
        chk("rsp3_data", 64'(rspd3), 64'(e3.data));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Returns cycles from accept to first rsp_valid; leaves the caller at that negedge.
  task automatic wait_rsp(input bit use3, output int lat);
    lat = 1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (use3 ? rspv3 : rspv0) return;
      lat++;
      step();
    end
  endtask

  logic [DW-1:0] opa [NR] = '{32'h3F800000, 32'h40000000, 32'h40000000, 32'h3FC00000};
  logic [DW-1:0] opb [NR] = '{32'h40000000, 32'h40000000, 32'h40400000, 32'h3FC00000};
  logic [DW-1:0] prd [NR] = '{32'h40000000, 32'h40800000, 32'h40C00000, 32'h40100000};
  int ord [6] = '{0, 1, 2, 3, 0, 1};

  initial begin
    int lat, g, last;
    logic [NR-1:0] exp_oh;
    rst = 1'b1;
    rv0 = '0; a0 = '0; b0 = '0; rspr0 = 1'b1;
    rv3 = '0; a3 = '0; b3 = '0; rspr3 = 1'b1;
    step();
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("reset_rsp_valid", 64'(rspv0), 64'd0);
    chk("reset_busy", 64'(busy0), 64'd0);
    chk("reset_fmul_a", 64'(fa0), 64'd0);
    chk("reset_rsp_data", 64'(rspd0), 64'd0);
    chk("reset_rsp_id", 64'(rspid0), 64'd0);
`ifdef FMUL_RR_SCHEDULER_STATS_EN
    chk("reset_stat_stall", 64'(ss0), 64'd0);
`endif

    // Single op from requester 2: 2.0 * 3.0
    step();
    a0[2*DW +: DW] = 32'h40000000;
    b0[2*DW +: DW] = 32'h40400000;
    rv0 = 4'b0100;
    q0.push_back('{id: 2'd2, data: 32'h40C00000});
    @(negedge clk);
    chk("single_req_ready", 64'(rr0), 64'(4'b0100));
    step();
    rv0 = '0;
    wait_rsp(1'b0, lat);
    chk("single_latency", 64'(lat), 64'd2);

    // All requesters valid after a fresh reset: strict rotation every 3 cycles
    step();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    for (int i = 0; i < NR; i++) begin
      a0[i*DW +: DW] = opa[i];
      b0[i*DW +: DW] = opb[i];
    end
    for (int i = 0; i < 6; i++) q0.push_back('{id: IW'(ord[i]), data: prd[ord[i]]});
    rv0 = 4'b1111;
    g = 0;
    last = 0;
    for (int cyc = 0; cyc < 40 && g < 6; cyc++) begin
      @(negedge clk);
      if (rr0 != '0) begin
        exp_oh = 4'b0001 << ord[g];
        chk("rotate_grant", 64'(rr0), 64'(exp_oh));
        if (g > 0) chk("rotate_gap", 64'(cyc - last), 64'd3);
        last = cyc;
        g++;
      end
      step();
      if (g == 6) rv0 = '0;
    end
    chk("rotate_count", 64'(g), 64'd6);
    repeat (4) step();
`ifdef FMUL_RR_SCHEDULER_STATS_EN
    chk("stat_grants_r0", 64'(sg0[0 +: 16]), 64'd2);
    chk("stat_grants_r3", 64'(sg0[48 +: 16]), 64'd1);
`endif

    // Backpressure: requester 1 computes 4.0 * 0.5, response stalled 10 cycles
    a0[1*DW +: DW] = 32'h40800000;
    b0[1*DW +: DW] = 32'h3F000000;
    rspr0 = 1'b0;
    rv0 = 4'b0010;
    q0.push_back('{id: 2'd1, data: 32'h40000000});
    @(negedge clk);
    chk("stall_accept", 64'(rr0), 64'(4'b0010));
    step();
    rv0 = '0;
    wait_rsp(1'b0, lat);
    chk("stall_latency", 64'(lat), 64'd2);
    for (int k = 0; k < 10; k++) begin
      chk("stall_valid", 64'(rspv0), 64'd1);
      chk("stall_data", 64'(rspd0), 64'h40000000);
      chk("stall_id", 64'(rspid0), 64'd1);
      chk("stall_no_grant", 64'(rr0), 64'd0);
      step();
      rv0 = (k == 2) ? 4'b0010 : ((k >= 4 && k <= 6) ? 4'b1111 : 4'b0000);
      if (k == 9) begin
        rv0 = '0;
        rspr0 = 1'b1;
      end
      @(negedge clk);
    end
    chk("stall_release_valid", 64'(rspv0), 64'd1);
`ifdef FMUL_RR_SCHEDULER_STATS_EN
    chk("stat_stall", 64'(ss0), 64'd10);
    chk("stat_grants_r1", 64'(sg0[16 +: 16]), 64'd3);
`endif
    step();
    @(negedge clk);
    chk("post_handshake_busy", 64'(busy0), 64'd0);
    chk("post_handshake_valid", 64'(rspv0), 64'd0);

    // Pipelined multiplier instance: 1.5 * 1.5 with MUL_LAT=3
    step();
    a3[0 +: DW] = 32'h3FC00000;
    b3[0 +: DW] = 32'h3FC00000;
    rv3 = 4'b0001;
    q3.push_back('{id: 2'd0, data: 32'h40100000});
    @(negedge clk);
    chk("lat3_accept", 64'(rr3), 64'(4'b0001));
    step();
    rv3 = '0;
    wait_rsp(1'b1, lat);
    chk("lat3_latency", 64'(lat), 64'd5);
    chk("lat3_fmul_a_held", 64'(fa3), 64'h3FC00000);

    // Reset during CALC drops requester 3's op; pointer restarts at 0
    step();
    rv0 = 4'b1000;
    @(negedge clk);
    chk("rst_mid_accept", 64'(rr0), 64'(4'b1000));
    step();
    rst = 1'b1;
    rv0 = 4'b1111;
    @(negedge clk);
    chk("rst_mid_calc_busy", 64'(busy0), 64'd1);
    step();
    @(negedge clk);
    chk("rst_ready_gated", 64'(rr0), 64'd0);
    chk("rst_busy", 64'(busy0), 64'd0);
    chk("rst_rsp_valid", 64'(rspv0), 64'd0);
`ifdef FMUL_RR_SCHEDULER_STATS_EN
    chk("rst_stat_grants", 64'(sg0), 64'd0);
`endif
    step();
    rst = 1'b0;
    q0.push_back('{id: 2'd0, data: prd[0]});
    @(negedge clk);
    chk("rst_ptr_zero", 64'(rr0), 64'(4'b0001));
    step();
    rv0 = '0;
    wait_rsp(1'b0, lat);
    chk("rst_next_latency", 64'(lat), 64'd2);
    repeat (20) step();

    chk("q0_drained", 64'(q0.size()), 64'd0);
    chk("q3_drained", 64'(q3.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fmul_rr_scheduler.md
Name: fmul_rr_scheduler

Overview:
- Shares one floating-point multiplier datapath (floatMul-style; combinational or pipelined) among NUM_REQ requesters in the CNN core.
- Round-robin arbitration over valid/ready request channels; one operation in flight at a time.
- Registered operands drive the multiplier. The product is captured after a configurable latency and returned on a single valid/ready response channel, tagged with the requester id.

Parameters:
- DATA_WIDTH, 32, operand/result width (16/32/64).
- NUM_REQ, 4, number of requesters (2..16).
- ID_WIDTH, $clog2(NUM_REQ), width of the requester id tag.
- MUL_LAT, 0, cycles from registered operands to a valid fmul_c (0 = combinational multiplier).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  per-requester accept; one-hot or zero.
- req_a  in  NUM_REQ*DATA_WIDTH  packed operand A; slice i is requester i.
- req_b  in  NUM_REQ*DATA_WIDTH  packed operand B.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response consumer ready.
- rsp_data  out  DATA_WIDTH  product A*B from the multiplier.
- rsp_id  out  ID_WIDTH  index of the granted requester.
- fmul_a  out  DATA_WIDTH  registered operand to the multiplier.
- fmul_b  out  DATA_WIDTH  registered operand to the multiplier.
- fmul_c  in  DATA_WIDTH  multiplier result.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Clock/reset: one clock (clk); rst is synchronous, active-high. rst forces:
  - state=IDLE, rr_ptr=0, lat_cnt=0;
  - fmul_a=fmul_b=0, rsp_data=0, rsp_id=0, rsp_valid=0, busy=0;
  - req_ready=0 during the rst cycle.
  - An in-flight operation is dropped; no response is produced for it.
- States:
  - IDLE: if any req_valid, grant the first set bit searching from rr_ptr upward with wrap. req_ready[g]=1 combinationally in that cycle only.
    - On the edge: fmul_a/fmul_b <= slices g; rsp_id <= g; rr_ptr <= (g+1) mod NUM_REQ; lat_cnt <= 0; go to CALC.
    - If no req_valid: req_ready=0, stay IDLE, rr_ptr unchanged.
  - CALC: lasts MUL_LAT+1 cycles; lat_cnt increments each cycle. On the cycle with lat_cnt==MUL_LAT: rsp_data <= fmul_c, go to RESP.
  - RESP: rsp_valid=1. rsp_data and rsp_id are held stable until rsp_ready. On rsp_valid&rsp_ready: rsp_valid <= 0, go to IDLE.
- req_ready is 0 in CALC and RESP. At most one bit is ever set; it is never set without the matching req_valid.
- Latency: accept in cycle T gives rsp_valid first high in cycle T+MUL_LAT+2. Minimum throughput is one op per MUL_LAT+3 cycles with rsp_ready held high.
- fmul_a/fmul_b are held constant from accept until the next accept; the multiplier sees stable inputs for the whole CALC window.
- Fairness: a continuously asserted requester is granted within NUM_REQ grants.
- Boundary cases:
  - Requester drops req_valid before grant: no grant, no side effect.
  - All requesters valid: strict rotation 0,1,2,...,NUM_REQ-1,0.
  - rr_ptr wraps from NUM_REQ-1 to 0.
  - rsp_ready high while rsp_valid is low: ignored.
  - rsp_ready stalled indefinitely: the block remains in RESP and new requests are not accepted.
- Width rules: lat_cnt is $clog2(MUL_LAT+1) bits, minimum 1. Slice i of req_a is bits [i*DATA_WIDTH +: DATA_WIDTH].

Optional Feature:
- FMUL_RR_SCHEDULER_STATS_EN defined:
  - Adds output stat_grants, NUM_REQ*16 bits; slice i counts grants to requester i.
  - Each counter saturates at 16'hFFFF and is cleared to 0 by rst.
  - Adds output stat_stall, 16 bits, saturating: counts cycles in RESP with rsp_ready=0.
- Undefined: neither port nor the counters exist; all other behaviour is identical.

Test Plan:
- Bench multiplier model returns the IEEE product with MUL_LAT=0. rst for 2 cycles, then requester 2 sends A=32'h40000000 (2.0), B=32'h40400000 (3.0). Required: req_ready=4'b0100 in the accept cycle; rsp_valid 2 cycles later with rsp_data=32'h40C00000 and rsp_id=2.
- All four requesters continuously valid, rsp_ready=1. Required: grant order 0,1,2,3,0,1, with req_ready asserted every 3rd cycle.
- MUL_LAT=3 build, requester 0 sends 1.5*1.5 (32'h3FC00000 each). Required: fmul_c sampled exactly 4 cycles after accept; rsp_data=32'h40100000 on rsp_valid in cycle T+5.
- Response backpressure: hold rsp_ready=0 for 10 cycles. Required: rsp_data/rsp_id stable throughout, all req_ready=0, and with STATS_EN stat_stall=10. Release gives one handshake, then IDLE.
- Reset mid-operation: assert rst during CALC. Required: next cycle IDLE, rsp_valid=0, rr_ptr=0, and no response is ever emitted for the dropped op.
- Requester 1 pulses req_valid for one cycle while the block is in RESP. Required: no grant and no stat_grants increment.
